fp_divider: RTL and testbench

Multi-cycle IEEE-754-style floating-point divider, the companion to the FPU multiplier. It computes fp_a / fp_b with a restoring radix-2 mantissa divider that produces one quotient bit per cycle, followed by one rounding cycle. It sits beside the multiplier in the FPU datapath and uses the same operand format, rounding-mode encoding and done/inv_op status conventions.

---
 rtl/fp_divider.sv | 201 ++++++++++++++++++++
 tb/tb_fp_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// Multi-cycle floating-point divider: restoring radix-2 mantissa division,
// one quotient bit per cycle, followed by a single rounding cycle.
module fp_divider #(
   parameter int precision     = 32,
   parameter int exp_size      = 8,
   parameter int mantissa_size = 23,
   parameter int exp_bias      = (1 << (exp_size - 1)) - 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [precision-1:0] fp_a,
   input  logic [precision-1:0] fp_b,
   input  logic [1:0]           rounding,
   output logic [precision-1:0] result,
   output logic                 inv_op,
   output logic                 div_by_zero,
   output logic                 busy,
   output logic                 done
);

   localparam int QW = mantissa_size + 3;
   localparam int RW = mantissa_size + 2;
   localparam int EW = exp_size + 2;
   localparam int CW = $clog2(QW);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << exp_size) - 1);

   typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, ROUND} state_t;

   state_t                 state;
   logic [precision-1:0]   a_reg, b_reg;
   logic [1:0]             rm_reg;
   logic [RW-1:0]          rem, dvs;
   logic [QW-1:0]          q;
   logic signed [EW-1:0]   exp_q;
   logic                   sign_q;
   logic [CW-1:0]          cnt;

   logic                     sign_a, sign_b, sign_ab;
   logic [exp_size-1:0]      exp_a, exp_b;
   logic [mantissa_size-1:0] frac_a, frac_b;

   assign sign_a  = a_reg[precision-1];
   assign sign_b  = b_reg[precision-1];
   assign sign_ab = sign_a ^ sign_b;
   assign exp_a   = a_reg[precision-2 -: exp_size];
   assign exp_b   = b_reg[precision-2 -: exp_size];
   assign frac_a  = a_reg[mantissa_size-1:0];
   assign frac_b  = b_reg[mantissa_size-1:0];

   // Special-operand classification; exponent field 0 is treated as zero (flush).
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic spec_hit, spec_inv, spec_dbz;
   logic [precision-1:0] spec_result, qnan_val, inf_val, zero_val;

   assign qnan_val = {1'b0, {exp_size{1'b1}}, 1'b1, {(mantissa_size-1){1'b0}}};
   assign inf_val  = {sign_ab, {exp_size{1'b1}}, {mantissa_size{1'b0}}};
   assign zero_val = {sign_ab, {(precision-1){1'b0}}};

   always_comb begin
      a_zero = (exp_a == '0);
      b_zero = (exp_b == '0);
      a_inf  = (exp_a == '1) && (frac_a == '0);
      b_inf  = (exp_b == '1) && (frac_b == '0);
      a_nan  = (exp_a == '1) && (frac_a != '0);
      b_nan  = (exp_b == '1) && (frac_b != '0);
      a_snan = a_nan && !frac_a[mantissa_size-1];
      b_snan = b_nan && !frac_b[mantissa_size-1];
      spec_hit    = 1'b1;
      spec_inv    = 1'b0;
      spec_dbz    = 1'b0;
      spec_result = zero_val;
      if (a_nan || b_nan) begin
         spec_result = qnan_val;
         spec_inv    = a_snan || b_snan;
      end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
         spec_result = qnan_val;
         spec_inv    = 1'b1;
      end else if (b_zero && !a_inf) begin
         spec_result = inf_val;
         spec_dbz    = 1'b1;
      end else if (a_inf) begin
         spec_result = inf_val;
      end else if (b_inf || a_zero) begin
         spec_result = zero_val;
      end else begin
         spec_hit = 1'b0;
      end
   end

   // One restoring step: keep the difference only when it did not go negative.
   logic [RW:0]   diff;
   logic          q_bit;
   logic [RW-1:0] next_rem;

   always_comb begin
      diff     = {1'b0, rem} - {1'b0, dvs};
      q_bit    = !diff[RW];
      next_rem = (q_bit ? diff[RW-1:0] : rem) << 1;
   end

   // Normalize, round and range-check the finished quotient.
   logic [QW-2:0]            norm_lo;
   logic signed [EW-1:0]     exp_n, exp_r;
   logic [mantissa_size-1:0] frac_k, frac_r;
   logic [mantissa_size:0]   frac_sum;
   logic                     guard, sticky, round_up;
   logic [precision-1:0]     round_result;

   always_comb begin
      norm_lo  = q[QW-1] ? q[QW-2:0] : {q[QW-3:0], 1'b0};
      exp_n    = q[QW-1] ? exp_q : exp_q - EW'(1);
      frac_k   = norm_lo[QW-2 -: mantissa_size];
      guard    = norm_lo[1];
      sticky   = norm_lo[0] | (|rem);
      case (rm_reg)
         2'b00:   round_up = sign_q & (guard | sticky);
         2'b01:   round_up = !sign_q & (guard | sticky);
         2'b10:   round_up = 1'b0;
         default: round_up = guard & (sticky | frac_k[0]);
      endcase
      frac_sum = {1'b0, frac_k} + {{mantissa_size{1'b0}}, round_up};
      exp_r    = exp_n + {{(EW-1){1'b0}}, frac_sum[mantissa_size]};
      frac_r   = frac_sum[mantissa_size-1:0];
      if (exp_r >= EXP_MAX)
         round_result = {sign_q, {exp_size{1'b1}}, {mantissa_size{1'b0}}};
      else if (exp_r[EW-1] || exp_r == '0)
         round_result = {sign_q, {(precision-1){1'b0}}};
      else
         round_result = {sign_q, exp_r[exp_size-1:0], frac_r};
   end

   // Control FSM; all status outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         rm_reg      <= '0;
         rem         <= '0;
         dvs         <= '0;
         q           <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         cnt         <= '0;
         result      <= '0;
         inv_op      <= 1'b0;
         div_by_zero <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg       <= fp_a;
                  b_reg       <= fp_b;
                  rm_reg      <= rounding;
                  done        <= 1'b0;
                  inv_op      <= 1'b0;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  state       <= CHECK;
               end
            end
            CHECK: begin
               if (spec_hit) begin
                  result      <= spec_result;
                  inv_op      <= spec_inv;
                  div_by_zero <= spec_dbz;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  rem    <= {1'b0, 1'b1, frac_a};
                  dvs    <= {1'b0, 1'b1, frac_b};
                  q      <= '0;
                  cnt    <= '0;
                  exp_q  <= EW'(exp_a) - EW'(exp_b) + EW'(exp_bias);
                  sign_q <= sign_ab;
                  state  <= DIVIDE;
               end
            end
            DIVIDE: begin
               rem <= next_rem;
               q   <= {q[QW-2:0], q_bit};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(QW - 1))
                  state <= ROUND;
            end
            ROUND: begin
               result <= round_result;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed corner cases plus random
// operands compared against an integer-arithmetic reference model.
module tb_fp_divider;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] fp_a = '0;
   logic [31:0] fp_b = '0;
   logic [1:0]  rounding = '0;
   logic [31:0] result;
   logic        inv_op, div_by_zero, busy, done;

   int total = 0;
   int bad   = 0;

   fp_divider dut (
      .clk(clk), .reset(reset), .start(start), .fp_a(fp_a), .fp_b(fp_b),
      .rounding(rounding), .result(result), .inv_op(inv_op),
      .div_by_zero(div_by_zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference: exact quotient via integer division, rounded from the remainder.
   function automatic logic [33:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] rm);
      int     ea, eb, e;
      longint fa, fb, num, den, sig, rmd, twice, rest;
      bit     sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
      bit     guard, sticky, up;
      ea = int'(a[30:23]);  eb = int'(b[30:23]);
      fa = longint'(a[22:0]); fb = longint'(b[22:0]);
      sign   = a[31] ^ b[31];
      a_zero = (ea == 0);   b_zero = (eb == 0);
      a_inf  = (ea == 255) && (fa == 0);  b_inf = (eb == 255) && (fb == 0);
      a_nan  = (ea == 255) && (fa != 0);  b_nan = (eb == 255) && (fb != 0);
      a_snan = a_nan && !a[22];           b_snan = b_nan && !b[22];
      if (a_nan || b_nan) return {a_snan | b_snan, 1'b0, 32'h7FC00000};
      if ((a_inf && b_inf) || (a_zero && b_zero)) return {2'b10, 32'h7FC00000};
      if (b_zero && !a_inf) return {2'b01, sign, 8'hFF, 23'h0};
      if (a_inf) return {2'b00, sign, 8'hFF, 23'h0};
      if (b_inf || a_zero) return {2'b00, sign, 31'h0};
      num = (64'd1 << 23) + fa;
      den = (64'd1 << 23) + fb;
      e   = ea - eb + 127;
      if (num < den) begin
         num = num * 2;
         e   = e - 1;
      end
      sig    = (num << 23) / den;
      rmd    = (num << 23) % den;
      twice  = rmd * 2;
      guard  = (twice >= den);
      rest   = guard ? twice - den : twice;
      sticky = (rest != 0);
      case (rm)
         2'b00:   up = sign && (guard || sticky);
         2'b01:   up = !sign && (guard || sticky);
         2'b10:   up = 1'b0;
         default: up = guard && (sticky || sig[0]);
      endcase
      if (up) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin
         sig = 64'd1 << 23;
         e   = e + 1;
      end
      if (e >= 255) return {2'b00, sign, 8'hFF, 23'h0};
      if (e <= 0) return {2'b00, sign, 31'h0};
      return {2'b00, sign, 8'(e), sig[22:0]};
   endfunction

   function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
             (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one operation, optionally pulse start mid-flight, and check everything.
   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                                 input bit poke, input bit has_plan, input logic [31:0] plan);
      logic [33:0] m;
      int          lat, exp_lat;
      bit          busy_ok;
      string       id;
      m       = model_div(a, b, rm);
      exp_lat = is_special(a, b) ? 1 : 28;
      id      = $sformatf("%h/%h rm%0d", a, b, rm);
      @(negedge clk);
      fp_a = a; fp_b = b; rounding = rm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; fp_a = $urandom; fp_b = $urandom; rounding = 2'($urandom);
      check_output({"done_clear ", id}, 32'(done), 32'd0);
      lat = 0; busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (poke && lat == 5) begin
            start = 1'b1; fp_a = 32'h3F800000; fp_b = 32'h40400000;
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
      check_output({"latency ", id}, 32'(lat), 32'(exp_lat));
      check_output({"busy_during ", id}, 32'(busy_ok), 32'd1);
      check_output({"busy_after ", id}, 32'(busy), 32'd0);
      check_output({"result ", id}, result, m[31:0]);
      check_output({"inv_op ", id}, 32'(inv_op), 32'(m[33]));
      check_output({"div_by_zero ", id}, 32'(div_by_zero), 32'(m[32]));
      if (has_plan) check_output({"plan ", id}, result, plan);
   endtask

   initial begin
      logic [31:0] ra, rb;
      #12;
      check_output("reset result", result, 32'h0);
      check_output("reset done", 32'(done), 32'd0);
      check_output("reset busy", 32'(busy), 32'd0);
      check_output("reset inv_op", 32'(inv_op), 32'd0);
      check_output("reset dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk); reset = 1'b1;

      apply_stimulus(32'h40C00000, 32'h40000000, 2'b11, 1'b0, 1'b1, 32'h40400000);
      apply_stimulus(32'h40C00000, 32'h40000000, 2'b11, 1'b1, 1'b1, 32'h40400000);
      apply_stimulus(32'h3F800000, 32'h40400000, 2'b11, 1'b0, 1'b1, 32'h3EAAAAAB);
      apply_stimulus(32'h3F800000, 32'h40400000, 2'b10, 1'b0, 1'b1, 32'h3EAAAAAA);
      apply_stimulus(32'hBF800000, 32'h40400000, 2'b00, 1'b0, 1'b1, 32'hBEAAAAAB);
      apply_stimulus(32'hBF800000, 32'h40400000, 2'b01, 1'b0, 1'b1, 32'hBEAAAAAA);
      apply_stimulus(32'h3F800000, 32'h00000000, 2'b11, 1'b0, 1'b1, 32'h7F800000);
      apply_stimulus(32'h00000000, 32'h00000000, 2'b11, 1'b0, 1'b1, 32'h7FC00000);
      apply_stimulus(32'h7FA00000, 32'h3F800000, 2'b11, 1'b0, 1'b1, 32'h7FC00000);
      apply_stimulus(32'h7F800001, 32'h3F800000, 2'b11, 1'b0, 1'b1, 32'h7FC00000);
      apply_stimulus(32'h7F800000, 32'h7F800000, 2'b11, 1'b0, 1'b1, 32'h7FC00000);
      apply_stimulus(32'hFF800000, 32'h40000000, 2'b11, 1'b0, 1'b1, 32'h7F800000 | 32'h80000000);
      apply_stimulus(32'h3F800000, 32'hFF800000, 2'b11, 1'b0, 1'b1, 32'h80000000);
      apply_stimulus(32'h7F000000, 32'h3E800000, 2'b11, 1'b0, 1'b1, 32'h7F800000);
      apply_stimulus(32'h00800000, 32'h40000000, 2'b11, 1'b0, 1'b1, 32'h00000000);
      apply_stimulus(32'h00400000, 32'h3F800000, 2'b11, 1'b0, 1'b1, 32'h00000000);
      apply_stimulus(32'h3FFFFFFF, 32'h3F800001, 2'b01, 1'b0, 1'b0, 32'h0);

      for (int i = 0; i < 60; i++) begin
         ra = $urandom; rb = $urandom;
         if (i % 8 != 0) begin
            ra[30:23] = 8'($urandom_range(60, 190));
            rb[30:23] = 8'($urandom_range(60, 190));
         end
         if (i % 11 == 3) ra[22:0] = '0;
         apply_stimulus(ra, rb, 2'($urandom), 1'b0, 1'b0, 32'h0);
      end

      // Abort a divide after its tenth iteration with an asynchronous reset.
      @(negedge clk);
      fp_a = 32'h40C00000; fp_b = 32'h40000000; rounding = 2'b11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #2; reset = 1'b0; #1;
      check_output("abort result", result, 32'h0);
      check_output("abort done", 32'(done), 32'd0);
      check_output("abort busy", 32'(busy), 32'd0);
      check_output("abort inv_op", 32'(inv_op), 32'd0);
      check_output("abort dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk); reset = 1'b1;
      apply_stimulus(32'h40C00000, 32'h40000000, 2'b11, 1'b0, 1'b1, 32'h40400000);

      $display("[TB] directed and random sequence complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
